fft_deserializer: RTL
=====================

Name: fft_deserializer

Overview:
- Upstream stage of the combinational FFT crossbar.
- Accepts real samples one per handshake on a latency-insensitive val/rdy stream and collects SIZE_FFT of them into one frame.
- Emits the frame as a single packed message in the crossbar's wide format: real half in the upper slices, imaginary half zero.
- Decouples the serial sample source (ADC/SPI side) from the parallel FFT datapath.

Parameters:
- BIT_WIDTH, 32, width of one sample (fixed-point, passed through untouched).
- SIZE_FFT, 8, samples per frame; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset), sampled on clk.
- recv_msg  in  BIT_WIDTH  incoming real sample.
- recv_val  in  1  recv_msg valid.
- recv_rdy  out  1  block can accept a sample this cycle.
- send_msg  out  BIT_WIDTH*SIZE_FFT*2  packed frame; real sample k at [BIT_WIDTH*(SIZE_FFT+k) +: BIT_WIDTH]; imaginary slice k at [BIT_WIDTH*k +: BIT_WIDTH], always 0.
- send_val  out  1  send_msg valid.
- send_rdy  in  1  downstream accepts frame.

Behaviour:
- Handshake:
  - Transfer occurs on a cycle where val && rdy.
  - recv_rdy never depends combinationally on recv_val.
  - send_val never depends on send_rdy.
  - send_msg is stable while send_val=1 and send_rdy=0.
- Counter: cnt, width $clog2(SIZE_FFT); index of the next sample slot. Samples are stored in arrival order; bit-reversal is the crossbar's job.
- State machine (default build), two states:
  - FILL: recv_rdy=1, send_val=0. Each recv fire writes buf[cnt] <= recv_msg and increments cnt. A fire with cnt==SIZE_FFT-1 wraps cnt to 0 and moves to SEND.
  - SEND: recv_rdy=0, send_val=1, send_msg driven from buf. A send fire returns to FILL.
- Latency: last sample accepted at edge t -> send_val=1 in the cycle after edge t (1 cycle). Minimum frame period is SIZE_FFT+1 cycles.
- recv_val=0 gaps inside a frame: cnt holds; there is no timeout.
- Reset (reset=0 at an edge):
  - state=FILL, cnt=0, all buffer slots=0, send_val=0, send_msg=0.
  - recv_rdy=0 while reset is low.
  - A partially filled frame is discarded. A pending unaccepted frame is dropped without send fire.
- Reset release: recv_rdy=1 on the first cycle with reset=1.
- Arithmetic: none; samples are copied bit-exact, no sign extension.

Optional Feature:
- Macro: FFT_DESER_PINGPONG_EN.
- Defined:
  - Two frame banks. Write bank fills while read bank is presented.
  - recv_rdy=0 only when both banks are full.
  - Completing a fill marks that bank full and swaps the write pointer. send_val=1 whenever the read bank is full.
  - A send fire frees the read bank and swaps the read pointer.
  - Last-sample fire and send fire in the same cycle are both honoured: no stall, no loss.
  - Sustained throughput is 1 sample/cycle.
  - Reset clears both banks and both pointers.
- Undefined: the single-buffer FSM above; recv_rdy=0 throughout SEND.

Test Plan:
- BIT_WIDTH=8, SIZE_FFT=4, send_rdy=1; send 0x11,0x22,0x33,0x44 back-to-back.
  -> send_val=1 exactly one cycle after the 0x44 fire.
  -> send_msg=0x44332211_00000000.
  -> recv_rdy=0 during that SEND cycle (default build).
- Same samples with recv_val deasserted 3 cycles between each.
  -> identical send_msg; send_val stays 0 until the 4th fire.
- Frame complete, send_rdy held 0 for 5 cycles.
  -> send_val=1 and send_msg stable for all 5; recv_rdy=0 (default build).
  -> single send fire when send_rdy=1; recv_rdy=1 next cycle.
- Two samples accepted, reset=0 for one cycle, then 0xA0,0xA1,0xA2,0xA3.
  -> send_msg=0xA3A2A1A0_00000000; no trace of the pre-reset samples.
- FFT_DESER_PINGPONG_EN defined, send_rdy=1, 12 samples 0x01..0x0C on consecutive cycles.
  -> recv_rdy never drops.
  -> three frames out in order: 0x04030201, 0x08070605, 0x0C0B0A09 (upper half), each with imaginary half 0.
- FFT_DESER_PINGPONG_EN defined, send_rdy=0.
  -> recv_rdy falls after the 8th fire.
  -> raising send_rdy for one cycle frees one bank; recv_rdy=1 on the next cycle.

Source files
------------

// File: rtl/fft_deserializer.sv
// Collects SIZE_FFT real samples from a val/rdy stream into one wide crossbar frame (imag half zero).
// Define FFT_DESER_PINGPONG_EN for double-buffered operation at 1 sample/cycle.
module fft_deserializer #(
  parameter int BIT_WIDTH = 32,
  parameter int SIZE_FFT  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BIT_WIDTH-1:0]              recv_msg,
  input  logic                              recv_val,
  output logic                              recv_rdy,
  output logic [BIT_WIDTH*SIZE_FFT*2-1:0]   send_msg,
  output logic                              send_val,
  input  logic                              send_rdy
);

  localparam int CW = (SIZE_FFT > 1) ? $clog2(SIZE_FFT) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE_FFT - 1);

  logic [CW-1:0] cnt;
  logic          recv_fire;
  logic          send_fire;

  assign recv_fire = recv_val & recv_rdy;
  assign send_fire = send_val & send_rdy;

`ifdef FFT_DESER_PINGPONG_EN

  logic [BIT_WIDTH-1:0] slots [2][SIZE_FFT];
  logic [1:0]           full;
  logic                 wr_ptr;
  logic                 rd_ptr;

  // The write bank is never the full read bank while it can accept, so fill and drain touch different bits.
  assign recv_rdy = reset & ~full[wr_ptr];
  assign send_val = full[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SIZE_FFT; i++) begin
          slots[b][i] <= '0;
        end
      end
    end else begin
      if (recv_fire) begin
        slots[wr_ptr][cnt] <= recv_msg;
        cnt                <= cnt + 1'b1;
        if (cnt == LAST) begin
          full[wr_ptr] <= 1'b1;
          wr_ptr       <= ~wr_ptr;
        end
      end
      if (send_fire) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
    end
  end

  for (genvar k = 0; k < SIZE_FFT; k++) begin : g_pack
    assign send_msg[BIT_WIDTH*(SIZE_FFT+k) +: BIT_WIDTH] = slots[rd_ptr][k];
    assign send_msg[BIT_WIDTH*k +: BIT_WIDTH]            = '0;
  end

`else

  typedef enum logic {FILL, SEND} state_t;

  state_t               state;
  logic [BIT_WIDTH-1:0] slots [SIZE_FFT];

  assign recv_rdy = reset & (state == FILL);
  assign send_val = (state == SEND);

  // cnt wraps to 0 by itself on the last sample because SIZE_FFT is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FILL;
      cnt   <= '0;
      for (int i = 0; i < SIZE_FFT; i++) begin
        slots[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (recv_fire) begin
            slots[cnt] <= recv_msg;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= SEND;
            end
          end
        end
        SEND: begin
          if (send_fire) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  for (genvar k = 0; k < SIZE_FFT; k++) begin : g_pack
    assign send_msg[BIT_WIDTH*(SIZE_FFT+k) +: BIT_WIDTH] = slots[k];
    assign send_msg[BIT_WIDTH*k +: BIT_WIDTH]            = '0;
  end

`endif

endmodule
